mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_pkg.sv | 52 +++++
 rtl/store_lane_gen.sv | 24 ++
 rtl/mem_access_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types, constants and helpers for the MEM-stage access controller.
package mem_access_ctrl_pkg;

    typedef logic [63:0] u64;
    typedef logic [2:0]  u3;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBus   = 2'd1,
        StResp  = 2'd2,
        StDrain = 2'd3
    } mac_state_t;

    // Low address bits that must be zero for a naturally aligned access.
    localparam u3 MisalignMask1 = 3'b000;
    localparam u3 MisalignMask2 = 3'b001;
    localparam u3 MisalignMask4 = 3'b011;
    localparam u3 MisalignMask8 = 3'b111;

    function automatic logic is_misaligned(u3 off, msize_t size);
        u3 mask;
        unique case (size)
            MSIZE1: mask = MisalignMask1;
            MSIZE2: mask = MisalignMask2;
            MSIZE4: mask = MisalignMask4;
            MSIZE8: mask = MisalignMask8;
        endcase
        return (off & mask) != 3'b000;
    endfunction

    // Select the addressed lane of the raw bus word and extend it to 64 bits.
    function automatic u64 load_extract(u64 rdata, u3 off, msize_t size, logic zext);
        u64 sh;
        u64 res;
        sh = rdata >> {off, 3'b000};
        unique case (size)
            MSIZE1: res = zext ? {56'b0, sh[7:0]}  : {{56{sh[7]}}, sh[7:0]};
            MSIZE2: res = zext ? {48'b0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            MSIZE4: res = zext ? {32'b0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            MSIZE8: res = rdata;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/store_lane_gen.sv
// Byte-strobe and write-lane alignment for stores onto the 64-bit data bus.
module store_lane_gen
    import mem_access_ctrl_pkg::*;
(
    input  logic [2:0] addr,
    input  msize_t     size,
    input  u64         wdata,
    output logic [7:0] strobe,
    output u64         wdata_lane
);

    always_comb begin
        strobe = 8'h00;
        unique case (size)
            MSIZE1: strobe = 8'h01 << addr;
            MSIZE2: strobe = 8'h03 << addr;
            MSIZE4: strobe = 8'h0F << addr;
            MSIZE8: strobe = 8'hFF;
        endcase
    end

    assign wdata_lane = wdata << {addr, 3'b000};

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: alignment check, bus handshake, load
// result alignment/extension and flush handling without aborting bus traffic.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter bit MISALIGN_CHECK = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  u64         req_addr,
    input  msize_t     req_size,
    input  logic       req_unsigned,
    input  u64         req_wdata,
    input  logic       flush,
    output logic       dbus_valid,
    output u64         dbus_addr,
    output msize_t     dbus_size,
    output logic [7:0] dbus_strobe,
    output u64         dbus_wdata,
    input  logic       dbus_data_ok,
    input  u64         dbus_rdata,
    output logic       resp_valid,
    output u64         resp_data,
    output logic       resp_misalign
);

    mac_state_t state_q, state_d;
    u64         addr_q, addr_d;
    msize_t     size_q, size_d;
    logic       write_q, write_d;
    logic       unsigned_q, unsigned_d;
    u64         wdata_q, wdata_d;
    u64         result_q, result_d;
    logic       misalign_q, misalign_d;

    logic [7:0] lane_strobe;
    u64         lane_wdata;
    logic       accept;
    logic       bus_active;

    store_lane_gen u_store_lane_gen (
        .addr       (addr_q[2:0]),
        .size       (size_q),
        .wdata      (wdata_q),
        .strobe     (lane_strobe),
        .wdata_lane (lane_wdata)
    );

    assign accept = req_valid && (state_q == StIdle) && !flush;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        write_d    = write_q;
        unsigned_d = unsigned_q;
        wdata_d    = wdata_q;
        result_d   = result_q;
        misalign_d = misalign_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d     = req_addr;
                    size_d     = req_size;
                    write_d    = req_write;
                    unsigned_d = req_unsigned;
                    wdata_d    = req_wdata;
                    result_d   = '0;
                    if (MISALIGN_CHECK && is_misaligned(req_addr[2:0], req_size)) begin
                        misalign_d = 1'b1;
                        state_d    = StResp;
                    end else begin
                        misalign_d = 1'b0;
                        state_d    = StBus;
                    end
                end
            end
            StBus: begin
                if (dbus_data_ok) begin
                    state_d  = flush ? StIdle : StResp;
                    result_d = write_q ? '0
                             : load_extract(dbus_rdata, addr_q[2:0], size_q, unsigned_q);
                end else if (flush) begin
                    // Transaction already issued; ride it out without a response.
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (dbus_data_ok) begin
                    state_d = StIdle;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            size_q     <= MSIZE1;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            wdata_q    <= '0;
            result_q   <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            write_q    <= write_d;
            unsigned_q <= unsigned_d;
            wdata_q    <= wdata_d;
            result_q   <= result_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus_active    = (state_q == StBus) || (state_q == StDrain);
    assign req_ready     = (state_q == StIdle);
    assign dbus_valid    = bus_active;
    assign dbus_addr     = addr_q;
    assign dbus_size     = size_q;
    assign dbus_strobe   = (bus_active && write_q) ? lane_strobe : 8'h00;
    assign dbus_wdata    = (bus_active && write_q) ? lane_wdata : '0;
    assign resp_valid    = (state_q == StResp);
    assign resp_data     = resp_valid ? result_q : '0;
    assign resp_misalign = resp_valid && misalign_q;

endmodule
